vga_score_overlay: RTL and testbench
====================================

Name: vga_score_overlay

Overview:
- Owns 640x480@60 VGA timing for the ping-pong display. Draws the left and right 4-bit scores as two 7-segment glyphs over a background colour supplied by the playfield/ball renderer.
- Outputs the final registered RGB, hs and vs to the pins.
- Exports raster coordinates and a pixel enable so the upstream renderer stays aligned.
- Latches scores once per frame and blinks the digit that just changed.

Parameters:
- CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz)
- H_SYNC 96, H_BACK 48, H_ACT 640, H_PERIOD 800, horizontal timing in pixels
- V_SYNC 2, V_BACK 33, V_ACT 480, V_PERIOD 525, vertical timing in lines
- L_X, 200, left digit x origin (active coordinates)
- R_X, 400, right digit x origin
- DIG_Y, 40, y origin of both digits
- DIG_W, 40, digit width
- DIG_H, 80, digit height
- SEG_T, 8, segment thickness
- FLASH_FRAMES, 32, blink duration after a score change

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- score_l  in  4  left score (Ls from game FSM), quasi-static
- score_r  in  4  right score (Rs)
- bg_rgb  in  3  {r,g,b} background for the coordinate issued one pixel earlier
- pix_en  out  1  one-clk pulse per pixel
- h_cnt  out  10  raster column 0..799 (stage 0)
- v_cnt  out  10  raster line 0..524 (stage 0)
- red/green/blue  out  1 each  final colour (stage 2)
- hs  out  1  hsync, active low (stage 2)
- vs  out  1  vsync, active low (stage 2)

Behaviour:
- Reset (rst=0, async):
  - div counter, h_cnt, v_cnt, pix_en, rgb, flash counter, frame counter and latched scores all 0.
  - Pipelined hs/vs regs reset to 1.
  - No output glitch on release.
- Pixel enable:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 only in the clk where div==CLK_DIV-1; first pulse is CLK_DIV clks after reset release.
  - All state below advances only when pix_en=1.
- Stage 0 (counters):
  - h_cnt increments and wraps 799->0.
  - On that wrap, v_cnt increments and wraps 524->0.
  - raw_hs = (h_cnt<H_SYNC)?0:1; raw_vs = (v_cnt<V_SYNC)?0:1.
  - active = 144<=h_cnt<784 and 35<=v_cnt<515.
  - Active coordinates: x=h_cnt-144, y=v_cnt-35.
- Frame start (pix_en with h_cnt==0 and v_cnt==0):
  - sc_l<=score_l, sc_r<=score_r; frame_cnt increments, 8-bit, wraps.
  - If new sc_l != old sc_l: flash_l<=FLASH_FRAMES. Likewise flash_r, independently.
  - Otherwise each nonzero flash counter decrements by 1.
  - Score changes mid-frame have no visible effect until the next frame start.
- Segment decode:
  - Hex 0..F, standard 7-seg (a top, b upper-right, c lower-right, d bottom, e lower-left, f upper-left, g middle).
  - A..F map to A,b,C,d,E,F.
- Glyph geometry, with (dx,dy) relative to the digit origin, valid inside 0<=dx<DIG_W, 0<=dy<DIG_H:
  - a: dy<SEG_T
  - d: dy>=DIG_H-SEG_T
  - g: DIG_H/2-SEG_T/2 <= dy < DIG_H/2+SEG_T/2
  - f: dx<SEG_T and dy<DIG_H/2
  - e: dx<SEG_T and dy>=DIG_H/2
  - b: dx>=DIG_W-SEG_T and dy<DIG_H/2
  - c: dx>=DIG_W-SEG_T and dy>=DIG_H/2
  - A hit requires active=1 and the segment lit.
- Stage 1: register hit_l, hit_r, raw_hs, raw_vs, active.
- Blink:
  - A digit is suppressed when its flash counter !=0 and frame_cnt[2]==1, i.e. 4 frames on / 4 off.
- Stage 2 (registered outputs):
  - active=0: rgb=000.
  - Unsuppressed hit_l: rgb=100.
  - Unsuppressed hit_r: rgb=001.
  - Otherwise rgb=bg_rgb.
  - Digits never overlap with default parameters; if both hit, left has priority.
  - hs/vs pass through from stage 1.
  - Total latency from h_cnt/v_cnt to pins is 2 pixels, identical for sync and colour.

Test Plan:
- Reset held 10 clks, then released:
  - During reset: hs=vs=1, rgb=000, h_cnt=v_cnt=0.
  - First pix_en at clk 4 after release.
  - hs falls at pixel 2.
- Free run:
  - hs period 3200 clks, low 384 clks.
  - vs period 1,680,000 clks, low 6400 clks.
  - rgb=000 whenever hs or vs is low.
- score_l=8, score_r=0, bg_rgb=010:
  - Pixel (L_X+1, DIG_Y+1) red.
  - Pixel (L_X+DIG_W/2, DIG_Y+DIG_H/2) red (segment g lit).
  - Same point on the right digit shows green (g off for 0).
  - Pixel (R_X+1, DIG_Y+DIG_H/2+5) blue.
- score_r changes 3->4 mid-frame:
  - Displayed digit stays 3 until the next v_cnt==0.
  - Then it blinks off on frames where frame_cnt[2]=1 for 32 frames, then shows steadily.
  - Left digit is unaffected.
- score_l=F:
  - Segments a, e, f, g lit; b, c, d off.
- rst asserted mid-line (h_cnt=500):
  - All outputs return to reset values in the same clk without waiting for a clock edge.
  - After release, counting restarts from 0,0.

Source files
------------

// File: rtl/vga_score_overlay.sv
// 640x480@60 VGA timing generator with a two-digit 7-segment score overlay.
// Raster counters form stage 0; glyph hits are registered in stage 1 and colour/sync leave stage 2.
module vga_score_overlay #(
   parameter int unsigned CLK_DIV      = 4,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BACK       = 48,
   parameter int unsigned H_ACT        = 640,
   parameter int unsigned H_PERIOD     = 800,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BACK       = 33,
   parameter int unsigned V_ACT        = 480,
   parameter int unsigned V_PERIOD     = 525,
   parameter int unsigned L_X          = 200,
   parameter int unsigned R_X          = 400,
   parameter int unsigned DIG_Y        = 40,
   parameter int unsigned DIG_W        = 40,
   parameter int unsigned DIG_H        = 80,
   parameter int unsigned SEG_T        = 8,
   parameter int unsigned FLASH_FRAMES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] score_l,
   input  logic [3:0] score_r,
   input  logic [2:0] bg_rgb,
   output logic       pix_en,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       red,
   output logic       green,
   output logic       blue,
   output logic       hs,
   output logic       vs
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned FL_W  = $clog2(FLASH_FRAMES + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [FL_W-1:0]  FLASH_C  = FL_W'(FLASH_FRAMES);

   localparam logic [9:0] H_LAST   = 10'(H_PERIOD - 1);
   localparam logic [9:0] V_LAST   = 10'(V_PERIOD - 1);
   localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
   localparam logic [9:0] H_ACT0   = 10'(H_SYNC + H_BACK);
   localparam logic [9:0] H_ACT1   = 10'(H_SYNC + H_BACK + H_ACT);
   localparam logic [9:0] V_ACT0   = 10'(V_SYNC + V_BACK);
   localparam logic [9:0] V_ACT1   = 10'(V_SYNC + V_BACK + V_ACT);
   localparam logic [9:0] L_X_C    = 10'(L_X);
   localparam logic [9:0] R_X_C    = 10'(R_X);
   localparam logic [9:0] DIG_Y_C  = 10'(DIG_Y);
   localparam logic [9:0] DIG_W_C  = 10'(DIG_W);
   localparam logic [9:0] DIG_H_C  = 10'(DIG_H);
   localparam logic [9:0] SEG_T_C  = 10'(SEG_T);
   localparam logic [9:0] SEG_R0   = 10'(DIG_W - SEG_T);
   localparam logic [9:0] SEG_D0   = 10'(DIG_H - SEG_T);
   localparam logic [9:0] HALF_H   = 10'(DIG_H / 2);
   localparam logic [9:0] MID_LO   = 10'(DIG_H / 2 - SEG_T / 2);
   localparam logic [9:0] MID_HI   = 10'(DIG_H / 2 + SEG_T / 2);

   // Segment bit order is {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'h0:    seg_decode = 7'h3F;
         4'h1:    seg_decode = 7'h06;
         4'h2:    seg_decode = 7'h5B;
         4'h3:    seg_decode = 7'h4F;
         4'h4:    seg_decode = 7'h66;
         4'h5:    seg_decode = 7'h6D;
         4'h6:    seg_decode = 7'h7D;
         4'h7:    seg_decode = 7'h07;
         4'h8:    seg_decode = 7'h7F;
         4'h9:    seg_decode = 7'h6F;
         4'hA:    seg_decode = 7'h77;
         4'hB:    seg_decode = 7'h7C;
         4'hC:    seg_decode = 7'h39;
         4'hD:    seg_decode = 7'h5E;
         4'hE:    seg_decode = 7'h79;
         default: seg_decode = 7'h71;
      endcase
   endfunction

   // Which segment areas cover a point inside the glyph box.
   function automatic logic [6:0] seg_area(input logic [9:0] dx, input logic [9:0] dy);
      logic upper;
      upper       = (dy < HALF_H);
      seg_area[0] = (dy < SEG_T_C);
      seg_area[1] = (dx >= SEG_R0) && upper;
      seg_area[2] = (dx >= SEG_R0) && !upper;
      seg_area[3] = (dy >= SEG_D0);
      seg_area[4] = (dx < SEG_T_C) && !upper;
      seg_area[5] = (dx < SEG_T_C) && upper;
      seg_area[6] = (dy >= MID_LO) && (dy < MID_HI);
   endfunction

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q, pix_en_d;
   logic [9:0]       h_q, h_d, v_q, v_d;
   logic [3:0]       sc_l_q, sc_l_d, sc_r_q, sc_r_d;
   logic [FL_W-1:0]  flash_l_q, flash_l_d, flash_r_q, flash_r_d;
   logic [7:0]       frame_q, frame_d;

   logic hit_l_q, hit_r_q, hs1_q, vs1_q, act1_q;
   logic [2:0] rgb_q, rgb_d;
   logic hs2_q, vs2_q;

   // Stage 0 combinational decode
   logic       raw_hs, raw_vs, active0, in_y, in_l, in_r, hit_l0, hit_r0;
   logic [9:0] x, y, dy, dx_l, dx_r;

   assign raw_hs  = (h_q >= H_SYNC_C);
   assign raw_vs  = (v_q >= V_SYNC_C);
   assign active0 = (h_q >= H_ACT0) && (h_q < H_ACT1) && (v_q >= V_ACT0) && (v_q < V_ACT1);
   assign x       = h_q - H_ACT0;
   assign y       = v_q - V_ACT0;
   assign dy      = y - DIG_Y_C;
   assign dx_l    = x - L_X_C;
   assign dx_r    = x - R_X_C;
   assign in_y    = (y >= DIG_Y_C) && (dy < DIG_H_C);
   assign in_l    = in_y && (x >= L_X_C) && (dx_l < DIG_W_C);
   assign in_r    = in_y && (x >= R_X_C) && (dx_r < DIG_W_C);
   assign hit_l0  = active0 && in_l && (|(seg_decode(sc_l_q) & seg_area(dx_l, dy)));
   assign hit_r0  = active0 && in_r && (|(seg_decode(sc_r_q) & seg_area(dx_r, dy)));

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
      div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      pix_en_d  = (div_d == DIV_LAST);
      h_d       = h_q;
      v_d       = v_q;
      sc_l_d    = sc_l_q;
      sc_r_d    = sc_r_q;
      flash_l_d = flash_l_q;
      flash_r_d = flash_r_q;
      frame_d   = frame_q;
      if (pix_en_q) begin
         h_d = (h_q == H_LAST) ? '0 : h_q + 10'd1;
         if (h_q == H_LAST) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
         end
         if (h_q == '0 && v_q == '0) begin
            sc_l_d  = score_l;
            sc_r_d  = score_r;
            frame_d = frame_q + 8'd1;
            if (score_l != sc_l_q)     flash_l_d = FLASH_C;
            else if (flash_l_q != '0)  flash_l_d = flash_l_q - FL_W'(1);
            if (score_r != sc_r_q)     flash_r_d = FLASH_C;
            else if (flash_r_q != '0)  flash_r_d = flash_r_q - FL_W'(1);
         end
      end
   end

   always_comb begin
      rgb_d = bg_rgb;
      if (!act1_q)                                          rgb_d = 3'b000;
      else if (hit_l_q && !(flash_l_q != '0 && frame_q[2])) rgb_d = 3'b100;
      else if (hit_r_q && !(flash_r_q != '0 && frame_q[2])) rgb_d = 3'b001;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q     <= '0;
         pix_en_q  <= 1'b0;
         h_q       <= '0;
         v_q       <= '0;
         sc_l_q    <= '0;
         sc_r_q    <= '0;
         flash_l_q <= '0;
         flash_r_q <= '0;
         frame_q   <= '0;
      end else begin
         // NOTE: non-blocking updates so every register sees pre-edge values of the others.
         div_q     <= div_d;
         pix_en_q  <= pix_en_d;
         h_q       <= h_d;
         v_q       <= v_d;
         sc_l_q    <= sc_l_d;
         sc_r_q    <= sc_r_d;
         flash_l_q <= flash_l_d;
         flash_r_q <= flash_r_d;
         frame_q   <= frame_d;
      end
   end

   // Stages 1 and 2 share one pixel-rate enable so sync and colour stay aligned.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_l_q <= 1'b0;
         hit_r_q <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         act1_q  <= 1'b0;
         rgb_q   <= 3'b000;
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
      end else if (pix_en_q) begin
         hit_l_q <= hit_l0;
         hit_r_q <= hit_r0;
         hs1_q   <= raw_hs;
         vs1_q   <= raw_vs;
         act1_q  <= active0;
         rgb_q   <= rgb_d;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
      end
   end

   assign pix_en = pix_en_q;
   assign h_cnt  = h_q;
   assign v_cnt  = v_q;
   assign red    = rgb_q[2];
   assign green  = rgb_q[1];
   assign blue   = rgb_q[0];
   assign hs     = hs2_q;
   assign vs     = vs2_q;

endmodule

// File: tb/tb_vga_score_overlay.sv
// Randomized scoreboard bench for vga_score_overlay on a shrunken raster so many frames fit.
// A frame-level reference model predicts every pin value; a monitor compares on each pixel.
module tb_vga_score_overlay;

   localparam int CLK_DIV  = 4;
   localparam int H_SYNC   = 4,  H_BACK = 4, H_ACT = 28, H_PERIOD = 40;
   localparam int V_SYNC   = 2,  V_BACK = 2, V_ACT = 20, V_PERIOD = 26;
   localparam int L_X      = 2,  R_X = 16,   DIG_Y = 2;
   localparam int DIG_W    = 10, DIG_H = 16, SEG_T = 2;
   localparam int FLASH    = 5;
   localparam int FP       = H_PERIOD * V_PERIOD;

   logic       clk, rst;
   logic [3:0] score_l, score_r;
   logic [2:0] bg_rgb;
   logic       pix_en, red, green, blue, hs, vs;
   logic [9:0] h_cnt, v_cnt;

   vga_score_overlay #(
      .CLK_DIV(CLK_DIV), .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACT(H_ACT), .H_PERIOD(H_PERIOD),
      .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACT(V_ACT), .V_PERIOD(V_PERIOD),
      .L_X(L_X), .R_X(R_X), .DIG_Y(DIG_Y), .DIG_W(DIG_W), .DIG_H(DIG_H), .SEG_T(SEG_T),
      .FLASH_FRAMES(FLASH)
   ) dut (
      .clk(clk), .rst(rst), .score_l(score_l), .score_r(score_r), .bg_rgb(bg_rgb),
      .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
      .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [4:0] pins;   // {r,g,b,hs,vs}
      int         h, v;
   } exp_t;
   exp_t exp_q[$];

   // Lit segments of each hex glyph, by name.
   string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   int m_sc_l, m_sc_r, m_flash_l, m_flash_r, m_frame;

   function automatic bit lit(input int d, input byte ch);
      string s = segs[d];
      for (int i = 0; i < s.len(); i++) if (s[i] == ch) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit digit_hit(input int d, input int dx, input int dy);
      bit upper;
      if (dx < 0 || dx >= DIG_W || dy < 0 || dy >= DIG_H) return 1'b0;
      upper = (dy < DIG_H / 2);
      if (lit(d, "a") && dy < SEG_T) return 1'b1;
      if (lit(d, "d") && dy >= DIG_H - SEG_T) return 1'b1;
      if (lit(d, "g") && dy >= DIG_H / 2 - SEG_T / 2 && dy < DIG_H / 2 + SEG_T / 2) return 1'b1;
      if (lit(d, "f") && dx < SEG_T && upper) return 1'b1;
      if (lit(d, "e") && dx < SEG_T && !upper) return 1'b1;
      if (lit(d, "b") && dx >= DIG_W - SEG_T && upper) return 1'b1;
      if (lit(d, "c") && dx >= DIG_W - SEG_T && !upper) return 1'b1;
      return 1'b0;
   endfunction

   function automatic exp_t model_pixel(input int j, input logic [2:0] bg);
      exp_t e;
      int h, v, x, y;
      bit act, blink, lh, rh;
      h = j % H_PERIOD;
      v = (j / H_PERIOD) % V_PERIOD;
      act = h >= H_SYNC + H_BACK && h < H_SYNC + H_BACK + H_ACT &&
            v >= V_SYNC + V_BACK && v < V_SYNC + V_BACK + V_ACT;
      x = h - (H_SYNC + H_BACK);
      y = v - (V_SYNC + V_BACK);
      blink = ((m_frame / 4) % 2) == 1;
      lh = digit_hit(m_sc_l, x - L_X, y - DIG_Y) && !(m_flash_l > 0 && blink);
      rh = digit_hit(m_sc_r, x - R_X, y - DIG_Y) && !(m_flash_r > 0 && blink);
      e.h = h;
      e.v = v;
      e.pins[4:2] = !act ? 3'b000 : lh ? 3'b100 : rh ? 3'b001 : bg;
      e.pins[1]   = (h >= H_SYNC);
      e.pins[0]   = (v >= V_SYNC);
      return e;
   endfunction

   task automatic model_reset();
      m_sc_l = 0; m_sc_r = 0; m_flash_l = 0; m_flash_r = 0; m_frame = 0;
   endtask

   task automatic model_frame_start();
      if (int'(score_l) != m_sc_l)  m_flash_l = FLASH;
      else if (m_flash_l > 0)       m_flash_l--;
      if (int'(score_r) != m_sc_r)  m_flash_r = FLASH;
      else if (m_flash_r > 0)       m_flash_r--;
      m_sc_l  = score_l;
      m_sc_r  = score_r;
      m_frame = (m_frame + 1) % 256;
   endtask

   // One iteration per pixel window (CLK_DIV clocks), starting just after the window's first clock.
   task automatic drive(input int n, input int mode);
      int   chg_off = 1;
      exp_t e;
      for (int w = 0; w < n; w++) begin
         int f = w / FP;
         int o = w % FP;
         check("h_cnt", h_cnt, w % H_PERIOD);
         check("v_cnt", v_cnt, (w / H_PERIOD) % V_PERIOD);
         if (o == 0) chg_off = $urandom_range(1, FP - 1);
         if (mode == 1 && w == 0) begin
            score_l = 4'($urandom_range(0, 15));
            score_r = 4'($urandom_range(0, 15));
         end
         if (o == chg_off) begin
            if (mode == 0) begin
               if (f == 2)  score_r = 4'd3;
               if (f == 3)  score_r = 4'd4;
               if (f == 9)  score_l = 4'hF;
               if (f >= 12) begin
                  score_l = 4'($urandom_range(0, 15));
                  score_r = 4'($urandom_range(0, 15));
               end
            end else begin
               score_l = 4'($urandom_range(0, 15));
               score_r = 4'($urandom_range(0, 15));
            end
         end
         bg_rgb = 3'($urandom_range(0, 7));
         if (w == 0) begin
            e.pins = 5'b000_11; e.h = -1; e.v = -1;
         end else begin
            e = model_pixel(w - 1, bg_rgb);
         end
         exp_q.push_back(e);
         if (o == 0) model_frame_start();
         for (int i = 0; i < CLK_DIV; i++) begin
            check("pix_en", pix_en, (i == CLK_DIV - 1) ? 1 : 0);
            @(negedge clk);
         end
      end
   endtask

   task automatic monitor(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         int t = 0;
         while (pix_en !== 1'b1 && t < 4 * CLK_DIV) begin
            @(negedge clk);
            t++;
         end
         if (t >= 4 * CLK_DIV) begin
            check("pix_en timeout", 0, 1);
            return;
         end
         @(negedge clk);
         if (exp_q.size() == 0) begin
            check("scoreboard underflow", 0, 1);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("pixel h=%0d v=%0d {rgb,hs,vs}", e.h, e.v),
                  {red, green, blue, hs, vs}, e.pins);
         end
      end
   endtask

   task automatic session(input int n, input int mode);
      model_reset();
      exp_q.delete();
      fork
         drive(n, mode);
         monitor(n);
      join
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " h_cnt"}, h_cnt, 0);
      check({tag, " v_cnt"}, v_cnt, 0);
      check({tag, " pix_en"}, pix_en, 0);
      check({tag, " rgb"}, {red, green, blue}, 0);
      check({tag, " hs"}, hs, 1);
      check({tag, " vs"}, vs, 1);
   endtask

   initial begin
      rst = 1'b0;
      score_l = 4'd8;
      score_r = 4'd0;
      bg_rgb  = 3'b010;
      repeat (10) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b1;
      session(14 * FP + 10 * H_PERIOD + 20, 0);

      // Asynchronous reset in the middle of a line, away from any clock edge.
      #1 rst = 1'b0;
      #1 check_reset_state("async reset");
      repeat (3) @(negedge clk);
      check_reset_state("reset held");
      rst = 1'b1;
      session(2 * FP + 100, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
